// File: rtl/pipelined_addsub_pkg.sv
// Shared ALU parameters and operation encoding for the ALU operation blocks.
package pipelined_addsub_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operation/result handshake bundle for the pipelined adder-subtractor.
// master = producer/consumer side, slave = the arithmetic block.
interface pipelined_addsub_if
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );

endinterface

// File: rtl/adder_segment.sv
// SEG-bit ripple adder built from 1-bit generate/propagate lookahead cells.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Ripple the carry through the per-bit lookahead cells
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[SEG-1:0];
  assign cout = c[SEG];
  assign cmsb = c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: each stage adds one SEG-bit segment (LSB first),
// with the untouched operand bits and finished result bits riding along in the
// stage registers. The last stage register is the registered output.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = ALU_STAGES
) (
  input logic               clk,
  input logic               reset,
  pipelined_addsub_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;

  logic                          advance;
  addsub_op_e                    op;
  logic [STAGES-1:0]             vld_q;
  logic [STAGES-1:0]             nxt_vld;
  logic [STAGES-1:0][WIDTH-1:0]  a_q;
  logic [STAGES-1:0][WIDTH-1:0]  b_q;
  logic [STAGES-1:0][WIDTH-1:0]  res_q;
  logic [STAGES-1:0][WIDTH-1:0]  nxt_a;
  logic [STAGES-1:0][WIDTH-1:0]  nxt_b;
  logic [STAGES-1:0][WIDTH-1:0]  nxt_res;
  logic [STAGES-1:0]             cy_q;
  logic [STAGES-1:0]             nxt_cy;
  logic [STAGES-1:0]             nxt_cmsb;
  logic                          ovf_q;
  logic                          zero_q;
  logic                          unused_bits;

  assign op = addsub_op_e'(bus.sub);

  // The whole pipe moves together; it only freezes when a finished result is
  // waiting on the consumer. Reset empties the pipe, so input is always open then.
  assign advance      = reset | ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] prev_res;
    logic [WIDTH-1:0] merged;
    logic [SEG-1:0]   seg_sum;
    logic             cin;

    if (k == 0) begin : g_first
      // Stage 0 adds straight from the inputs; subtraction is A + ~B + 1
      assign op_a       = bus.a;
      assign op_b       = (op == OP_SUB) ? ~bus.b : bus.b;
      assign cin        = (op == OP_SUB);
      assign prev_res   = '0;
      assign nxt_vld[k] = bus.in_valid;
    end else begin : g_next
      assign op_a       = a_q[k-1];
      assign op_b       = b_q[k-1];
      assign cin        = cy_q[k-1];
      assign prev_res   = res_q[k-1];
      assign nxt_vld[k] = vld_q[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .x    (op_a[k*SEG +: SEG]),
      .y    (op_b[k*SEG +: SEG]),
      .cin  (cin),
      .sum  (seg_sum),
      .cout (nxt_cy[k]),
      .cmsb (nxt_cmsb[k])
    );

    // Drop this stage's segment sum into the partially built result
    always_comb begin
      merged                  = prev_res;
      merged[k*SEG +: SEG]    = seg_sum;
    end

    assign nxt_res[k] = merged;
    assign nxt_a[k]   = op_a;
    assign nxt_b[k]   = op_b;
  end

  // Advance every stage register in lockstep, or hold them all on backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      vld_q  <= nxt_vld;
      a_q    <= nxt_a;
      b_q    <= nxt_b;
      res_q  <= nxt_res;
      cy_q   <= nxt_cy;
      ovf_q  <= nxt_cy[STAGES-1] ^ nxt_cmsb[STAGES-1];
      zero_q <= (nxt_res[STAGES-1] == '0);
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = res_q[STAGES-1];
  assign bus.cout      = cy_q[STAGES-1];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

  // Operands in the final stage and lower-stage MSB carries have no consumer
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], nxt_cmsb};

endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES, with 1 <= STAGES <= WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an operation is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the pipeline accepts an operation this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits, operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits, operand B.
REQ-009 The block SHALL have port sub, input, 1 bit: 0 gives A+B, 1 gives A-B.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result is presented.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-012 The block SHALL have port result, output, WIDTH bits, the sum or difference modulo 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1 bit, the carry out of the MSB (for sub, 1 = no borrow).
REQ-014 The block SHALL have port overflow, output, 1 bit, two's-complement signed overflow.
REQ-015 The block SHALL have port zero, output, 1 bit, set when result == 0.

Function
REQ-016 The operand SHALL be split into STAGES segments of SEG = WIDTH/STAGES bits; stage k SHALL add segment k, LSB segment first.
REQ-017 Stage k SHALL take its carry-in from the stage k-1 carry registered with the operation; stage 0 carry-in SHALL equal sub.
REQ-018 For sub=1, B SHALL be bitwise inverted at stage 0 capture, so that A + ~B + 1 is computed.
REQ-019 Unprocessed upper operand segments and completed lower result segments SHALL travel with their operation through the pipeline registers (skew/deskew).
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid with no stall.
REQ-021 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-022 Global advance = ~out_valid | out_ready; in_ready SHALL equal advance; when advance=0, all stage registers including valid bits SHALL hold.
REQ-023 A bubble (in_valid=0 while advancing) SHALL propagate as an invalid stage; its data is don't-care.
REQ-024 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-025 result, cout, overflow and zero SHALL be registered outputs and stable while out_valid & ~out_ready.
REQ-026 Operations SHALL complete in acceptance order; none may be dropped or duplicated under any out_ready pattern.
REQ-027 Simultaneous accept and emit in one cycle SHALL both take effect.

Reset
REQ-028 While reset is high at a clk edge, all stage valid bits and out_valid SHALL clear to 0, and result, cout, overflow and zero SHALL clear to 0.
REQ-029 Reset asserted mid-operation SHALL discard every in-flight operation; out_valid SHALL be 0 the cycle after reset.
REQ-030 in_ready SHALL be 1 during and immediately after reset (the pipeline is empty).

Structure
REQ-031 Default WIDTH/STAGES values SHALL live in the shared ALU parameters file reused by the other ALU operation blocks.
REQ-032 One sub-module, adder_segment (SEG-bit ripple adder with cin and cout, built from the existing 1-bit lookahead cell), SHALL be instantiated once per stage.

Verification
REQ-033 W=32,S=4: a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, overflow=1, cout=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-034 a=0xFFFFFFFF, b=1, sub=0 -> result=0, cout=1, zero=1, overflow=0.
REQ-035 a=5, b=5, sub=1 -> result=0, zero=1, cout=1; a=3, b=5, sub=1 -> result=0xFFFFFFFE, cout=0.
REQ-036 Issue 6 back-to-back ops with out_ready=0 for 5 cycles -> in_ready drops once the pipe fills; after release, all 6 results emerge in order with correct values and no loss.
REQ-037 Assert reset for 1 cycle while 3 ops are in flight -> out_valid=0 the next cycle, no stale result ever emitted, and the next op has latency 4.
REQ-038 W=8,S=1: a=0x80, b=0x01, sub=1 -> result=0x7F, overflow=1, cout=1, latency 1.
